mod_n_monitor: RTL and testbench
================================

// Module: mod_n_monitor
// PURPOSE
//  Receive-side checker for a modulo-N counter stream (mod_n style: clk/ce/rst -> y).
//  Samples the counter value on every enabled clock, locks onto the sequence, and
//  flags any step that is not v -> (v+1) mod N. Sits next to the counter as a
//  self-check / link monitor; reports lock, error pulses and wrap/error statistics.
// PARAMETERS
//  WIDTH        9    bit width of y_in
//  N            500  modulus of the monitored counter (2 <= N <= 2**WIDTH)
//  LOCK_THRESH  4    consecutive correct steps required to declare lock (>=1)
//  CW           16   width of statistics counters err_cnt / wrap_cnt
// PORTS
//  clk       in   1      rising-edge clock, single clock domain
//  rst       in   1      synchronous reset, active-high
//  ce        in   1      sample enable; y_in is valid only when ce=1
//  y_in      in   WIDTH  counter value under observation
//  locked    out  1      1 = sequence tracked, >= LOCK_THRESH good steps since (re)acquire
//  err       out  1      one-cycle pulse on sequence violation while locked
//  err_cnt   out  CW     number of err pulses since reset, saturating
//  wrap_cnt  out  CW     number of locked N-1 -> 0 wraps since reset, modulo 2**CW
// BEHAVIOUR
//  - Reset: rst=1 at a rising edge -> state IDLE, locked=0, err=0, err_cnt=0, wrap_cnt=0,
//    expected=0, match counter=0. rst has priority over ce. Reset mid-lock is the same.
//  - All outputs registered; response visible after the edge that samples y_in (1-cycle latency).
//  - ce=0: no state, counter or output change, except err (forced 0).
//  - next(v) = (v == N-1) ? 0 : v+1. Out of range means y_in >= N.
//  - FSM (evaluated only on ce=1 edges):
//    IDLE   : y_in in range -> expected=next(y_in), matches=0, ACQ. Out of range -> stay IDLE.
//    ACQ    : y_in==expected -> matches+1, expected=next(y_in); matches reaching
//             LOCK_THRESH -> LOCKED, locked=1 on that same edge.
//             y_in!=expected, in range -> reseed: expected=next(y_in), matches=0, stay ACQ.
//             Out of range -> IDLE. No err is raised in ACQ/IDLE.
//    LOCKED : y_in==expected -> expected=next(y_in); if y_in==0 and previous sample was N-1
//             then wrap_cnt+1.
//             Mismatch, in range -> err=1 for one cycle, err_cnt+1, locked=0, reseed, ACQ.
//             Out of range -> err=1, err_cnt+1, locked=0, IDLE.
//  - err_cnt saturates at 2**CW-1. wrap_cnt wraps to 0.
//  - A repeated value (counter stalled with ce=1) is a mismatch.
//  - N=2**WIDTH: out of range is impossible and that check is constant-folded away.
// CONFIGURATION
//  MOD_N_MONITOR_STATS_EN
//   defined  : err_cnt and wrap_cnt are implemented as above.
//   undefined: no counter registers; err_cnt and wrap_cnt are driven constant 0.
//              Ports are still present. locked and err are unchanged.
// TESTING  (WIDTH=9, N=500, LOCK_THRESH=4, CW=16, 2 ns clock, ce=1 unless stated)
//  1 rst 2 cycles, then y_in=0,1,2,3,4 -> locked=0 through sample 3, locked=1 after edge of
//    sample 4. err never 1.
//  2 locked, y_in=497,498,499,0,1 -> wrap_cnt=1 after the edge of 0, err=0, locked stays 1.
//  3 locked at y_in=100, next y_in=123 -> err=1 for exactly 1 cycle, err_cnt=1, locked=0;
//    then 124..127 -> relock after 127.
//  4 locked, ce=0 for 10 cycles with y_in=300 held, then ce=1 with 301 -> no err, locked stays 1.
//  5 locked, y_in=500 -> err pulse, err_cnt+1, IDLE; y_in=7,8,9,10,11 -> locked after 11.
//  6 rst=1 while locked with err_cnt=3 -> next edge: all outputs 0.
//    Rebuild without MOD_N_MONITOR_STATS_EN and rerun 3 -> err pulses, err_cnt stays 0.

Source files
------------

// File: rtl/mod_n_monitor.sv
// mod_n_monitor: locks onto a mod-N counter stream and flags broken steps; MOD_N_MONITOR_STATS_EN adds err/wrap counters
module mod_n_monitor #(
    parameter int WIDTH       = 9,
    parameter int N           = 500,
    parameter int LOCK_THRESH = 4,
    parameter int CW          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] y_in,
    output logic             locked,
    output logic             err,
    output logic [CW-1:0]    err_cnt,
    output logic [CW-1:0]    wrap_cnt
);
    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam logic [WIDTH:0]   N_W  = N[WIDTH:0];
    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
    localparam logic [MW-1:0]    LT   = MW'(LOCK_THRESH);
    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_exp;
    logic [MW-1:0]    r_match;
    logic             r_locked, r_err;
    logic             w_oor, w_hit, w_err_ev;
    logic [WIDTH-1:0] w_next;
    logic [MW-1:0]    w_match_inc;
    assign w_oor       = (N == (1 << WIDTH)) ? 1'b0 : ({1'b0, y_in} >= N_W);
    assign w_next      = (y_in == LAST) ? '0 : y_in + 1'b1;
    assign w_hit       = (y_in == r_exp);
    assign w_match_inc = r_match + 1'b1;
    assign w_err_ev    = ce && (r_state == S_LOCKED) && !w_hit;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_exp    <= '0;
            r_match  <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_err_ev;
            if (ce) begin
                case (r_state)
                    S_IDLE: if (!w_oor) begin
                        r_exp   <= w_next;
                        r_match <= '0;
                        r_state <= S_ACQ;
                    end
                    S_ACQ: if (w_oor) begin
                        r_state <= S_IDLE;
                    end else if (w_hit) begin
                        r_exp   <= w_next;
                        r_match <= w_match_inc;
                        if (w_match_inc == LT) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else begin
                        r_exp   <= w_next;
                        r_match <= '0;
                    end
                    S_LOCKED: begin
                        r_exp <= w_next;
                        if (!w_hit) begin
                            r_locked <= 1'b0;
                            r_match  <= '0;
                            r_state  <= w_oor ? S_IDLE : S_ACQ;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
    assign locked = r_locked;
    assign err    = r_err;
`ifdef MOD_N_MONITOR_STATS_EN
    // A hit on 0 while locked implies the previous sample was N-1, i.e. a wrap.
    logic          w_wrap_ev;
    logic [CW-1:0] r_err_cnt, r_wrap_cnt;
    assign w_wrap_ev = ce && (r_state == S_LOCKED) && w_hit && (y_in == '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt  <= '0;
            r_wrap_cnt <= '0;
        end else begin
            if (w_err_ev && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_wrap_ev) r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end
    assign err_cnt  = r_err_cnt;
    assign wrap_cnt = r_wrap_cnt;
`else
    assign err_cnt  = '0;
    assign wrap_cnt = '0;
`endif
endmodule

// File: tb/tb_mod_n_monitor.sv
// tb_mod_n_monitor: scoreboard bench for mod_n_monitor, expectations from an independent reference model
`timescale 1ns/1ps
module tb_mod_n_monitor;
    localparam int WIDTH = 9;
    localparam int N     = 500;
    localparam int LT    = 4;
    localparam int CW    = 16;
`ifdef MOD_N_MONITOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef struct packed {
        logic          locked;
        logic          err;
        logic [CW-1:0] ec;
        logic [CW-1:0] wc;
    } exp_t;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ce = 1'b0;
    logic [WIDTH-1:0] y_in = '0;
    logic             locked, err;
    logic [CW-1:0]    err_cnt, wrap_cnt;
    exp_t             q[$];
    int n_checks = 0;
    int n_fail = 0;
    int m_state = 0, m_exp = 0, m_match = 0, m_prev = 0, m_ec = 0, m_wc = 0;
    logic m_locked = 1'b0, m_err = 1'b0;
    int cur = 0;

    mod_n_monitor #(.WIDTH(WIDTH), .N(N), .LOCK_THRESH(LT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .y_in(y_in),
        .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic model(input logic r, input logic c, input int y);
        bit oor;
        int nx;
        if (r) begin
            m_state = 0; m_exp = 0; m_match = 0; m_locked = 1'b0; m_err = 1'b0; m_ec = 0; m_wc = 0;
        end else begin
            m_err = 1'b0;
            if (c) begin
                oor = (y >= N);
                nx  = (y == N - 1) ? 0 : y + 1;
                if (m_state == 2) begin
                    if (y == m_exp) begin
                        if (y == 0 && m_prev == N - 1) m_wc = (m_wc + 1) % (1 << CW);
                    end else begin
                        m_err = 1'b1;
                        if (m_ec < (1 << CW) - 1) m_ec++;
                        m_locked = 1'b0;
                        m_match = 0;
                        m_state = oor ? 0 : 1;
                    end
                    m_exp = nx;
                end else if (oor) begin
                    m_state = 0;
                end else if (m_state == 1 && y == m_exp) begin
                    m_match++;
                    if (m_match == LT) begin
                        m_state = 2;
                        m_locked = 1'b1;
                    end
                    m_exp = nx;
                end else begin
                    m_state = 1;
                    m_match = 0;
                    m_exp = nx;
                end
                m_prev = y;
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input int y);
        exp_t e;
        @(negedge clk);
        rst = r; ce = c; y_in = WIDTH'(y);
        model(r, c, y);
        q.push_back('{m_locked, m_err, STATS ? CW'(m_ec) : '0, STATS ? CW'(m_wc) : '0});
        @(posedge clk);
        #0.5;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("locked", 32'(locked), 32'(e.locked));
            chk("err", 32'(err), 32'(e.err));
            chk("err_cnt", 32'(err_cnt), 32'(e.ec));
            chk("wrap_cnt", 32'(wrap_cnt), 32'(e.wc));
        end
    endtask

    initial begin
        step(1, 0, 0);
        step(1, 0, 0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i <= 3; i++) step(0, 1, i);
        chk("t1_not_locked_yet", 32'(locked), 32'd0);
        step(0, 1, 4);
        chk("t1_locked", 32'(locked), 32'd1);
        for (int i = 5; i <= 499; i++) step(0, 1, i);
        step(0, 1, 0);
        chk("t2_wrap", 32'(wrap_cnt), STATS ? 32'd1 : 32'd0);
        chk("t2_locked", 32'(locked), 32'd1);
        for (int i = 1; i <= 100; i++) step(0, 1, i);
        step(0, 1, 123);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_unlocked", 32'(locked), 32'd0);
        for (int i = 124; i <= 127; i++) step(0, 1, i);
        chk("t3_relock", 32'(locked), 32'd1);
        for (int i = 128; i <= 300; i++) step(0, 1, i);
        for (int i = 0; i < 10; i++) step(0, 0, 300);
        step(0, 1, 301);
        chk("t4_hold_locked", 32'(locked), 32'd1);
        chk("t4_no_err", 32'(err), 32'd0);
        step(0, 1, 500);
        chk("t5_oor_err", 32'(err), 32'd1);
        for (int i = 7; i <= 11; i++) step(0, 1, i);
        chk("t5_relock", 32'(locked), 32'd1);
        step(0, 1, 12);
        step(0, 1, 12);
        chk("stall_err", 32'(err), 32'd1);
        for (int i = 13; i <= 16; i++) step(0, 1, i);
        chk("t6_err_cnt", 32'(err_cnt), STATS ? 32'd3 : 32'd0);
        step(1, 1, 17);
        chk("t6_rst_locked", 32'(locked), 32'd0);
        chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("t6_rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
        cur = 490;
        for (int i = 0; i < 600; i++) begin
            automatic int sel = int'($urandom_range(0, 39));
            automatic int y = (cur == N - 1) ? 0 : cur + 1;
            if (sel == 0) y = int'($urandom_range(0, 511));
            else if (sel == 1) y = cur;
            step(sel == 2, $urandom_range(0, 5) != 0, y);
            if (ce) cur = y;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
